// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection sequencer with pedestrian walk phase.
// A prescaler makes a one-cycle tick every TICK_CYC clocks; a tick counter times
// each phase. A pedestrian request, latched at any time, inserts WALK after the
// next all-red phase. Lamp outputs are active-low and registered one cycle after
// the state register.
// Optional build macro TRAFFIC_FLASH_MODE_EN: while i_enable=0 both directions
// flash yellow on every tick instead of freezing. The FSM stays held.
module traffic_light_ctrl #(
  parameter int TICK_CYC = 50000000,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_ped_req,
  output logic [2:0] o_ns_led,
  output logic [2:0] o_ew_led,
  output logic       o_walk_blink,
  output logic [2:0] o_state
);

  localparam logic [2:0] NS_G  = 3'd0;
  localparam logic [2:0] NS_Y  = 3'd1;
  localparam logic [2:0] AR_NS = 3'd2;
  localparam logic [2:0] EW_G  = 3'd3;
  localparam logic [2:0] EW_Y  = 3'd4;
  localparam logic [2:0] AR_EW = 3'd5;
  localparam logic [2:0] WALK  = 3'd6;

  // Active-low lamp patterns {R,Y,G}
  localparam logic [2:0] LED_G   = 3'b110;
  localparam logic [2:0] LED_Y   = 3'b101;
  localparam logic [2:0] LED_R   = 3'b011;
  localparam logic [2:0] LED_OFF = 3'b111;

  localparam int PW   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int MX1  = (GREEN_S > YELLOW_S) ? GREEN_S : YELLOW_S;
  localparam int MX2  = (ALLRED_S > WALK_S) ? ALLRED_S : WALK_S;
  localparam int MAXD = (MX1 > MX2) ? MX1 : MX2;
  localparam int SW   = $clog2(MAXD + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [SW-1:0] GREEN_M1   = SW'(GREEN_S - 1);
  localparam logic [SW-1:0] YELLOW_M1  = SW'(YELLOW_S - 1);
  localparam logic [SW-1:0] ALLRED_M1  = SW'(ALLRED_S - 1);
  localparam logic [SW-1:0] WALK_M1    = SW'(WALK_S - 1);

  logic [PW-1:0] presc_q;
  logic          presc_run;
  logic          presc_wrap;
  logic          tick;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [SW-1:0] dur_m1;
  logic          ped_lat_q, ped_lat_d;
  logic          walk_to_ew_q, walk_to_ew_d;  // WALK exits to EW_G (entered from AR_NS)

  logic [2:0]    ns_d, ew_d, st_d;
  logic          walk_d;

`ifdef TRAFFIC_FLASH_MODE_EN
  logic          flash_q;
  assign presc_run = 1'b1;
`else
  assign presc_run = i_enable;
`endif

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign tick       = i_enable && presc_wrap;

  // Prescaler, phase timer, pedestrian latch and FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      state_q      <= AR_EW;
      sec_q        <= '0;
      ped_lat_q    <= 1'b0;
      walk_to_ew_q <= 1'b0;
    end else begin
      if (presc_run)
        presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
      ped_lat_q <= ped_lat_d;
      // Illegal code 7 recovers even while the sequencer is frozen
      if (i_enable || (state_q == 3'd7)) begin
        state_q      <= state_d;
        sec_q        <= sec_d;
        walk_to_ew_q <= walk_to_ew_d;
      end
    end
  end

  // Next state: advance on the tick that ends the current phase
  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    walk_to_ew_d = walk_to_ew_q;
    ped_lat_d    = ped_lat_q | i_ped_req;
    case (state_q)
      NS_G, EW_G:   dur_m1 = GREEN_M1;
      NS_Y, EW_Y:   dur_m1 = YELLOW_M1;
      AR_NS, AR_EW: dur_m1 = ALLRED_M1;
      default:      dur_m1 = WALK_M1;
    endcase
    if (state_q == 3'd7) begin
      state_d = AR_EW;
      sec_d   = '0;
    end else if (tick) begin
      if (sec_q == dur_m1) begin
        sec_d = '0;
        case (state_q)
          NS_G:  state_d = NS_Y;
          NS_Y:  state_d = AR_NS;
          AR_NS: begin
            state_d      = ped_lat_q ? WALK : EW_G;
            walk_to_ew_d = 1'b1;
          end
          EW_G:  state_d = EW_Y;
          EW_Y:  state_d = AR_EW;
          AR_EW: begin
            state_d      = ped_lat_q ? WALK : NS_G;
            walk_to_ew_d = 1'b0;
          end
          default: state_d = walk_to_ew_q ? EW_G : NS_G;
        endcase
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
    // Entering WALK serves the request; a request on that same edge is absorbed
    if ((state_d == WALK) && (state_q != WALK))
      ped_lat_d = 1'b0;
  end

  // Output decode from the current state (lamps active-low)
  always_comb begin
    ns_d   = LED_R;
    ew_d   = LED_R;
    walk_d = 1'b0;
    st_d   = state_q;
    case (state_q)
      NS_G:    ns_d = LED_G;
      NS_Y:    ns_d = LED_Y;
      EW_G:    ew_d = LED_G;
      EW_Y:    ew_d = LED_Y;
      WALK:    walk_d = 1'b1;
      default: ;
    endcase
`ifdef TRAFFIC_FLASH_MODE_EN
    if (!i_enable) begin
      ns_d   = flash_q ? LED_OFF : LED_Y;
      ew_d   = flash_q ? LED_OFF : LED_Y;
      walk_d = 1'b0;
    end
`endif
  end

`ifdef TRAFFIC_FLASH_MODE_EN
  // Flash phase: restarts at yellow-on each time sequencing is disabled
  always_ff @(posedge clk) begin
    if (reset || i_enable)
      flash_q <= 1'b0;
    else if (presc_wrap)
      flash_q <= ~flash_q;
  end
`endif

  // Registered outputs, one cycle behind the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ns_led     <= LED_R;
      o_ew_led     <= LED_R;
      o_walk_blink <= 1'b0;
      o_state      <= AR_EW;
    end else begin
      o_ns_led     <= ns_d;
      o_ew_led     <= ew_d;
      o_walk_blink <= walk_d;
      o_state      <= st_d;
    end
  end

endmodule
